// File: rtl/cva6_tid_tracker_pkg.sv
// Shared types and helpers for the outstanding-request tracker.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package cva6_tid_tracker_pkg;

  // Life cycle of one tracked request slot.
  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_KILLED  = 2'd2,
    ST_DONE    = 2'd3
  } entry_state_e;

  // True when the ID width can address every entry.
  function automatic bit tid_width_ok(input int unsigned nr_entries,
                                      input int unsigned tid_width);
    return (nr_entries >= 1) && (tid_width >= $clog2(nr_entries));
  endfunction

endpackage

// File: rtl/cva6_tid_tracker_lzc.sv
// Trailing-zero counter: index of the lowest set bit, plus an all-zero flag.
// Latency: purely combinational.
// Backpressure: n/a.
module cva6_tid_tracker_lzc #(
  parameter int unsigned Width = 2,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] in_i,
  output logic [IdxW-1:0]  cnt_o,
  output logic             empty_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    cnt_o = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (in_i[i]) cnt_o = IdxW'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/cva6_tid_tracker.sv
// Allocates transaction IDs, holds per-request metadata, releases completed requests.
// Latency: response to out_valid_o one cycle; release frees the entry for the next cycle.
// Backpressure: alloc_ready_o low when the target entry is busy or flushing; out held until out_ready_i.
module cva6_tid_tracker
  import cva6_tid_tracker_pkg::*;
#(
  parameter int unsigned NrEntries    = 2,
  parameter int unsigned TidWidth     = 2,
  parameter int unsigned PayloadWidth = 64,
  parameter bit          InOrder      = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            alloc_valid_i,
  output logic                            alloc_ready_o,
  input  logic [PayloadWidth-1:0]         alloc_payload_i,
  output logic [TidWidth-1:0]             alloc_tid_o,
  input  logic                            rsp_valid_i,
  input  logic [TidWidth-1:0]             rsp_tid_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [TidWidth-1:0]             out_tid_o,
  output logic [PayloadWidth-1:0]         out_payload_o,
  output logic [$clog2(NrEntries+1)-1:0]  count_o,
  output logic                            busy_o
);

  localparam int unsigned IdxW = (NrEntries > 1) ? $clog2(NrEntries) : 1;
  localparam int unsigned CntW = $clog2(NrEntries + 1);

  if (!tid_width_ok(NrEntries, TidWidth)) begin : g_param_err
    $error("cva6_tid_tracker: TidWidth cannot address NrEntries");
  end

  entry_state_e            state_q [NrEntries];
  entry_state_e            state_d [NrEntries];
  logic [PayloadWidth-1:0] payload_q [NrEntries];

  logic [IdxW-1:0] tgt_idx, rel_idx, rsp_idx;
  logic            tgt_free, rel_vld, rsp_hit;
  logic            alloc_fire, out_fire;
  logic [CntW-1:0] cnt_c;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(NrEntries - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Out-of-range IDs never address an entry.
  assign rsp_hit = rsp_valid_i && (32'(rsp_tid_i) < NrEntries);
  assign rsp_idx = IdxW'(rsp_tid_i);

  // Flush masks both handshakes so nothing is allocated or released in that cycle.
  assign alloc_ready_o = tgt_free && !flush_i;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign alloc_tid_o   = TidWidth'(tgt_idx);
  assign out_valid_o   = rel_vld && !flush_i;
  assign out_fire      = out_valid_o && out_ready_i;
  assign out_tid_o     = TidWidth'(rel_idx);
  assign out_payload_o = payload_q[rel_idx];
  assign count_o       = cnt_c;
  assign busy_o        = (cnt_c != '0);

  // Entry state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= '{default: ST_FREE};
    else         state_q <= state_d;
  end

  // Entry next state: response, then release/alloc, then flush on top of the result.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < NrEntries; i++) begin
      if (rsp_hit && rsp_idx == IdxW'(i)) begin
        if (state_q[i] == ST_PENDING)     state_d[i] = ST_DONE;
        else if (state_q[i] == ST_KILLED) state_d[i] = ST_FREE;
      end
      if (out_fire && rel_idx == IdxW'(i))   state_d[i] = ST_FREE;
      if (alloc_fire && tgt_idx == IdxW'(i)) state_d[i] = ST_PENDING;
      if (flush_i) begin
        if (state_d[i] == ST_PENDING)   state_d[i] = ST_KILLED;
        else if (state_d[i] == ST_DONE) state_d[i] = ST_FREE;
      end
    end
  end

  // Occupancy derived from entry states.
  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < NrEntries; i++) begin
      if (state_q[i] != ST_FREE) cnt_c = cnt_c + CntW'(1);
    end
  end

  // Metadata captured on allocation; cleared on reset so outputs start at zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)         payload_q <= '{default: '0};
    else if (alloc_fire) payload_q[tgt_idx] <= alloc_payload_i;
  end

  if (InOrder) begin : g_inorder
    logic [IdxW-1:0] head_q, head_d, tail_q, tail_d;

    assign tgt_idx  = tail_q;
    assign tgt_free = (state_q[tail_q] == ST_FREE);
    assign rel_idx  = head_q;
    assign rel_vld  = (state_q[head_q] == ST_DONE);

    // Head skips slots already freed by killed responses so it cannot stall behind them.
    always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (out_fire || (state_q[head_q] == ST_FREE && cnt_c != '0)) head_d = wrap_inc(head_q);
      if (alloc_fire) tail_d = wrap_inc(tail_q);
    end

    // Ring pointer registers.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        head_q <= head_d;
        tail_q <= tail_d;
      end
    end
  end else begin : g_ooo
    logic [NrEntries-1:0] free_vec, done_vec;
    logic                 free_none, done_none;

    // Per-entry flags feeding the two priority pickers.
    always_comb begin
      free_vec = '0;
      done_vec = '0;
      for (int i = 0; i < NrEntries; i++) begin
        free_vec[i] = (state_q[i] == ST_FREE);
        done_vec[i] = (state_q[i] == ST_DONE);
      end
    end

    cva6_tid_tracker_lzc #(.Width(NrEntries), .IdxW(IdxW)) u_lzc_free (
      .in_i(free_vec), .cnt_o(tgt_idx), .empty_o(free_none)
    );
    cva6_tid_tracker_lzc #(.Width(NrEntries), .IdxW(IdxW)) u_lzc_done (
      .in_i(done_vec), .cnt_o(rel_idx), .empty_o(done_none)
    );

    assign tgt_free = !free_none;
    assign rel_vld  = !done_none;
  end

endmodule
